// File: rtl/prog_fetch_pkg.sv
// Shared types and default constants for the program fetch sequencer.
package prog_fetch_pkg;

  localparam int DEFAULT_AW          = 8;
  localparam int DEFAULT_OPERAND_BIT = 3;

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    DECODE    = 3'd1,
    FETCH_ARG = 3'd2,
    VALID     = 3'd3,
    HALT      = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0]            opcode;
    logic [7:0]            operand;
    logic [DEFAULT_AW-1:0] pc;
  } bundle_t;

endpackage

// File: rtl/prog_fetch.sv
// Program fetch sequencer: owns the PC, reads opcode/operand from a 1-cycle ROM
// and hands complete instructions over valid/ready. PROG_FETCH_BREAK_EN adds a breakpoint.
module prog_fetch
  import prog_fetch_pkg::*;
#(
  parameter int            AW          = DEFAULT_AW,
  parameter logic [AW-1:0] RESET_PC    = '0,
  parameter int            OPERAND_BIT = DEFAULT_OPERAND_BIT
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [7:0]    instr_opcode,
  output logic [7:0]    instr_operand,
  output logic [AW-1:0] instr_pc,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  input  logic          halt,
  output logic          halted
`ifdef PROG_FETCH_BREAK_EN
  ,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr
`endif
);

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [7:0]    opcode_reg, opcode_next;
  logic [7:0]    operand_reg, operand_next;
  logic [AW-1:0] ipc_reg, ipc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FETCH_OP;
      pc_reg      <= RESET_PC;
      opcode_reg  <= '0;
      operand_reg <= '0;
      ipc_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      opcode_reg  <= opcode_next;
      operand_reg <= operand_next;
      ipc_reg     <= ipc_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    opcode_next  = opcode_reg;
    operand_next = operand_reg;
    ipc_next     = ipc_reg;
    rom_addr     = pc_reg;
    case (state_reg)
      FETCH_OP: begin
        state_next = DECODE;
`ifdef PROG_FETCH_BREAK_EN
        if (bp_en && (pc_reg == bp_addr)) state_next = HALT;
`endif
      end
      DECODE: begin
        // Address the operand byte now so it arrives in FETCH_ARG.
        rom_addr    = pc_reg + AW'(1);
        opcode_next = rom_data;
        ipc_next    = pc_reg;
        if (rom_data[OPERAND_BIT]) begin
          state_next = FETCH_ARG;
        end else begin
          operand_next = '0;
          pc_next      = pc_reg + AW'(1);
          state_next   = VALID;
        end
      end
      FETCH_ARG: begin
        operand_next = rom_data;
        pc_next      = pc_reg + AW'(2);
        state_next   = VALID;
      end
      VALID: begin
        if (instr_ready) begin
          if (halt) begin
            state_next = HALT;
          end else begin
            if (jump) pc_next = jump_addr;
            state_next = FETCH_OP;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH_OP;
      end
    endcase
  end

  assign instr_valid   = (state_reg == VALID);
  assign halted        = (state_reg == HALT);
  assign instr_opcode  = opcode_reg;
  assign instr_operand = operand_reg;
  assign instr_pc      = ipc_reg;

endmodule

// File: tb/tb_prog_fetch.sv
// Self-checking bench for prog_fetch: behavioural ROM plus a scoreboard of expected bundles.
module tb_prog_fetch;
  import prog_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic       jump = 1'b0;
  logic [7:0] jump_addr = '0;
  logic       halt = 1'b0;
  logic       halted;
`ifdef PROG_FETCH_BREAK_EN
  logic       bp_en = 1'b0;
  logic [7:0] bp_addr = '0;
`endif

  logic [7:0] rom [256];
  bundle_t    exp_q[$];
  int         checks = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  prog_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_operand(instr_operand),
    .instr_pc     (instr_pc),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .halt         (halt),
    .halted       (halted)
`ifdef PROG_FETCH_BREAK_EN
    ,
    .bp_en        (bp_en),
    .bp_addr      (bp_addr)
`endif
  );

  function automatic string fmt(input bundle_t b);
    return $sformatf("op=%02h arg=%02h pc=%02h", b.opcode, b.operand, b.pc);
  endfunction

  function automatic bundle_t mk(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] pc);
    bundle_t b;
    b.opcode  = op;
    b.operand = arg;
    b.pc      = pc;
    return b;
  endfunction

  task automatic rom_seq();
    for (int i = 0; i < 256; i++) rom[i] = 8'(i + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    jump = 1'b0;
    halt = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Waits (bounded) for a handshake, returns the bundle and the cycles waited before it.
  task automatic collect(input int budget, output bundle_t b, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    b = '0;
    while (!ok && cycles < budget) begin
      if (instr_valid && instr_ready) begin
        b = mk(instr_opcode, instr_operand, instr_pc);
        ok = 1'b1;
        $display("bundle %s after %0d cycles", fmt(b), cycles);
        @(negedge clk);
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    bundle_t b;
    int      cyc;
    bit      ok;
    rom_seq();
    @(negedge clk);
    rst = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: valid=%b halted=%b, want 0 0", instr_valid, halted);
    end
    checks++;
    if (mk(instr_opcode, instr_operand, instr_pc) !== mk(8'h00, 8'h00, 8'h00)) begin
      fails++;
      $display("FAIL reset_bundle: %s, want all zero", fmt(mk(instr_opcode, instr_operand, instr_pc)));
    end
    checks++;
    if (rom_addr !== 8'h00) begin
      fails++;
      $display("FAIL reset_rom_addr: %02h, want 00", rom_addr);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(8'h01, 8'h00, 8'h00));
    exp_q.push_back(mk(8'h02, 8'h00, 8'h01));
    collect(10, b, cyc, ok);
    checks++;
    if (!ok || cyc !== 2) begin
      fails++;
      $display("FAIL one_byte_latency: ok=%0d cycles=%0d, want 2", ok, cyc);
    end
    checks++;
    if (b !== exp_q[0]) begin
      fails++;
      $display("FAIL one_byte_first: %s, want %s", fmt(b), fmt(exp_q[0]));
    end
    void'(exp_q.pop_front());
    collect(10, b, cyc, ok);
    checks++;
    if (!ok || b !== exp_q[0]) begin
      fails++;
      $display("FAIL one_byte_second: ok=%0d %s, want %s", ok, fmt(b), fmt(exp_q[0]));
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_operand();
    bundle_t b, e;
    int      cyc;
    bit      ok;
    rom_seq();
    rom[0] = 8'h08;
    rom[1] = 8'h5A;
    rom[2] = 8'h01;
    do_reset();
    exp_q.push_back(mk(8'h08, 8'h5A, 8'h00));
    exp_q.push_back(mk(8'h01, 8'h00, 8'h02));
    collect(10, b, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || cyc !== 3) begin
      fails++;
      $display("FAIL two_byte_latency: ok=%0d cycles=%0d, want 3", ok, cyc);
    end
    checks++;
    if (b !== e) begin
      fails++;
      $display("FAIL two_byte_bundle: %s, want %s", fmt(b), fmt(e));
    end
    collect(10, b, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin
      fails++;
      $display("FAIL two_byte_next: ok=%0d %s, want %s", ok, fmt(b), fmt(e));
    end
  endtask

  task automatic test_stall();
    bundle_t b, e;
    int      cyc;
    int      bad;
    bit      ok;
    rom_seq();
    do_reset();
    instr_ready = 1'b0;
    exp_q.push_back(mk(8'h01, 8'h00, 8'h00));
    exp_q.push_back(mk(8'h02, 8'h00, 8'h01));
    cyc = 0;
    while (!instr_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    // Jump requests while stalled must be ignored.
    jump = 1'b1;
    jump_addr = 8'h40;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (instr_valid !== 1'b1 || mk(instr_opcode, instr_operand, instr_pc) !== exp_q[0] ||
          rom_addr !== 8'h01) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL stall_stable: %0d unstable cycles, want 0 (%s valid=%b rom_addr=%02h)",
               bad, fmt(mk(instr_opcode, instr_operand, instr_pc)), instr_valid, rom_addr);
    end
    jump = 1'b0;
    instr_ready = 1'b1;
    collect(10, b, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || cyc !== 0 || b !== e) begin
      fails++;
      $display("FAIL stall_release: ok=%0d cycles=%0d %s, want 0 %s", ok, cyc, fmt(b), fmt(e));
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_handshake: valid=%b after handshake, want 0", instr_valid);
    end
    collect(10, b, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin
      fails++;
      $display("FAIL jump_ignored: ok=%0d %s, want %s", ok, fmt(b), fmt(e));
    end
  endtask

  task automatic test_jump();
    bundle_t b, e;
    int      cyc;
    bit      ok;
    rom_seq();
    rom[8'h40] = 8'h03;
    do_reset();
    exp_q.push_back(mk(8'h01, 8'h00, 8'h00));
    exp_q.push_back(mk(8'h03, 8'h00, 8'h40));
    jump = 1'b1;
    jump_addr = 8'h40;
    collect(10, b, cyc, ok);
    jump = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin
      fails++;
      $display("FAIL jump_src: ok=%0d %s, want %s", ok, fmt(b), fmt(e));
    end
    collect(10, b, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin
      fails++;
      $display("FAIL jump_target: ok=%0d %s, want %s", ok, fmt(b), fmt(e));
    end
  endtask

  task automatic test_halt();
    bundle_t b, e;
    int      cyc;
    int      bad;
    bit      ok;
    rom_seq();
    do_reset();
    exp_q.push_back(mk(8'h01, 8'h00, 8'h00));
    halt = 1'b1;
    jump = 1'b1;
    jump_addr = 8'h40;
    collect(10, b, cyc, ok);
    halt = 1'b0;
    jump = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin
      fails++;
      $display("FAIL halt_bundle: ok=%0d %s, want %s", ok, fmt(b), fmt(e));
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (halted !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== 8'h01) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL halt_hold: %0d bad cycles (halted=%b valid=%b rom_addr=%02h), want 0",
               bad, halted, instr_valid, rom_addr);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_cleared: halted=%b, want 0", halted);
    end
    exp_q.push_back(mk(8'h01, 8'h00, 8'h00));
    collect(10, b, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin
      fails++;
      $display("FAIL restart_bundle: ok=%0d %s, want %s", ok, fmt(b), fmt(e));
    end
  endtask

  task automatic test_wrap();
    bundle_t b, e;
    int      cyc;
    bit      ok;
    rom_seq();
    rom[8'h00] = 8'h77;
    rom[8'hFF] = 8'h08;
    do_reset();
    exp_q.push_back(mk(8'h77, 8'h00, 8'h00));
    exp_q.push_back(mk(8'h08, 8'h77, 8'hFF));
    exp_q.push_back(mk(8'h02, 8'h00, 8'h01));
    jump = 1'b1;
    jump_addr = 8'hFF;
    collect(10, b, cyc, ok);
    jump = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin
      fails++;
      $display("FAIL wrap_first: ok=%0d %s, want %s", ok, fmt(b), fmt(e));
    end
    collect(10, b, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin
      fails++;
      $display("FAIL wrap_operand: ok=%0d %s, want %s", ok, fmt(b), fmt(e));
    end
    collect(10, b, cyc, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || b !== e) begin
      fails++;
      $display("FAIL wrap_next_pc: ok=%0d %s, want %s", ok, fmt(b), fmt(e));
    end
  endtask

`ifdef PROG_FETCH_BREAK_EN
  task automatic test_breakpoint();
    bundle_t b, e;
    int      cyc;
    int      seen;
    bit      ok;
    rom_seq();
    bp_en = 1'b1;
    bp_addr = 8'h02;
    do_reset();
    exp_q.push_back(mk(8'h01, 8'h00, 8'h00));
    exp_q.push_back(mk(8'h02, 8'h00, 8'h01));
    for (int i = 0; i < 2; i++) begin
      collect(10, b, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || b !== e) begin
        fails++;
        $display("FAIL bp_bundle%0d: ok=%0d %s, want %s", i, ok, fmt(b), fmt(e));
      end
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (instr_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0 || halted !== 1'b1 || rom_addr !== 8'h02) begin
      fails++;
      $display("FAIL bp_halt: valid_cycles=%0d halted=%b rom_addr=%02h, want 0 1 02",
               seen, halted, rom_addr);
    end
    bp_en = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_operand();
    test_stall();
    test_jump();
    test_halt();
    test_wrap();
`ifdef PROG_FETCH_BREAK_EN
    test_breakpoint();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
